// File: rtl/dualmem_pkg.sv
// Shared types and widths for the dual-port RAM port controller.
// Request and response bundles used between the controller and its FIFO.
package dualmem_pkg;

    localparam int DUALMEM_ADDR_W = 11;
    localparam int DUALMEM_DATA_W = 64;
    localparam int DUALMEM_BE_W   = DUALMEM_DATA_W / 8;
    localparam int DUALMEM_ID_W   = 4;

    typedef struct packed {
        logic                      we;
        logic [DUALMEM_ADDR_W-1:0] addr;
        logic [DUALMEM_DATA_W-1:0] wdata;
        logic [DUALMEM_BE_W-1:0]   be;
        logic [DUALMEM_ID_W-1:0]   id;
    } dualmem_req_t;

    typedef struct packed {
        logic                      wr;
        logic [DUALMEM_DATA_W-1:0] rdata;
        logic [DUALMEM_ID_W-1:0]   id;
    } dualmem_rsp_t;

endpackage

// File: rtl/dualmem_rsp_fifo.sv
// Response FIFO for the RAM port controller.
// Circular buffer of dualmem_rsp_t; a push into a full FIFO is taken only with a same-cycle pop.
module dualmem_rsp_fifo
    import dualmem_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  dualmem_rsp_t     push_data,
    input  logic             pop,
    output dualmem_rsp_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    dualmem_rsp_t     mem_q [DEPTH];
    dualmem_rsp_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Next storage, pointers and occupancy from push/pop
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // State registers; reset flushes and zeroes the head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dualmem_port_ctrl.sv
// Tagged request/response front-end for one port of the 64-bit byte-write BRAM.
// Define DUALMEM_PORT_CTRL_WRACK_EN to make writes take a credit and return an ack.
module dualmem_port_ctrl
    import dualmem_pkg::*;
#(
    parameter int ADDR_W    = DUALMEM_ADDR_W,
    parameter int DATA_W    = DUALMEM_DATA_W,
    parameter int ID_W      = DUALMEM_ID_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ID_W-1:0]     req_id,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [ID_W-1:0]     rsp_id,
    output logic                rsp_wr,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

`ifdef DUALMEM_PORT_CTRL_WRACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    dualmem_req_t     req;
    dualmem_rsp_t     push_data;
    dualmem_rsp_t     head;
    logic             accept;
    logic             takes_credit;
    logic             rsp_pop;
    logic             inflight_q, inflight_d;
    logic             infl_wr_q, infl_wr_d;
    logic [ID_W-1:0]  infl_id_q, infl_id_d;
    logic             req_ready_q, req_ready_d;
    logic [CNT_W:0]   occ_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign req = '{
        we:    req_we,
        addr:  req_addr,
        wdata: req_wdata,
        be:    req_be,
        id:    req_id
    };

    // RAM port drive: active only in the accept cycle
    always_comb begin
        accept   = req_valid && req_ready_q && !rst;
        mem_en   = accept;
        mem_we   = (accept && req.we) ? req.be : '0;
        mem_addr = accept ? req.addr : '0;
        mem_din  = accept ? req.wdata : '0;
    end

    // Credit tracking, next in-flight slot and registered ready
    always_comb begin
        takes_credit = WRACK || !req.we;
        inflight_d   = accept && takes_credit;
        infl_wr_d    = WRACK && req.we;
        infl_id_d    = req.id;
        rsp_pop      = !fifo_empty && rsp_ready;
        occ_next     = (CNT_W+1)'(fifo_count)
                     + (CNT_W+1)'(inflight_q)
                     - (CNT_W+1)'(rsp_pop)
                     + (CNT_W+1)'(inflight_d);
        req_ready_d  = !rst && (occ_next < (CNT_W+1)'(RSP_DEPTH));
        push_data.wr    = infl_wr_q;
        push_data.rdata = infl_wr_q ? '0 : mem_dout;
        push_data.id    = infl_id_q;
    end

    // In-flight slot and ready registers; reset drops any in-flight read
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            infl_wr_q   <= 1'b0;
            infl_id_q   <= '0;
            req_ready_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            infl_wr_q   <= infl_wr_d;
            infl_id_q   <= infl_id_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Credit limit guarantees the capture never meets a full FIFO without a pop
    always_comb begin : overflow_guard
        if (!rst) begin
            assert (!(fifo_full && inflight_q && !rsp_pop));
        end
    end

    dualmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (push_data),
        .pop       (rsp_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign req_ready = req_ready_q && !rst;
    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = head.rdata;
    assign rsp_id    = head.id;
    assign rsp_wr    = WRACK && head.wr;

endmodule

// File: tb/tb_dualmem_port_ctrl.sv
// Self-checking bench for dualmem_port_ctrl with a BRAM model and a
// queue-based response model checked every cycle.
module tb_dualmem_port_ctrl;

    localparam int DEPTH = 2;

`ifdef DUALMEM_PORT_CTRL_WRACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [10:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [3:0]  req_id;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic [3:0]  rsp_id;
    logic        rsp_wr;
    logic        mem_en;
    logic [7:0]  mem_we;
    logic [10:0] mem_addr;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;
    logic        ram_init;

    always #5 clk = ~clk;

    dualmem_port_ctrl #(
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_id    (req_id),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_id    (rsp_id),
        .rsp_wr    (rsp_wr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        logic [15:0] a;
        a = i[15:0];
        return {a, 16'hA5C3 ^ (a * 16'd7), a * 16'd13, 16'h5A3C ^ a};
    endfunction

    // Byte-write BRAM port, registered read
    logic [63:0] ram [2048];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_word(i);
        end else if (mem_en) begin
            for (int b = 0; b < 8; b++)
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            if (mem_we == 8'h00) mem_dout <= ram[mem_addr];
        end
    end

    // Reference model: shadow memory plus in-order queue of expected responses
    typedef struct {
        bit          wr;
        logic [63:0] data;
        logic [3:0]  id;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    logic [3:0]  popped_ids[$];
    logic [63:0] shadow [2048];
    int          outst = 0;
    int          cyc = 0;
    bit          after_rst = 1'b0;
    bit          model_init = 1'b0;

    always @(negedge clk) begin : model
        bit          acc;
        bit          exp_ready;
        bit          exp_valid;
        logic [7:0]  exp_we;
        logic [63:0] w;
        cyc++;
        if (!model_init) begin
            for (int i = 0; i < 2048; i++) shadow[i] = init_word(i);
            model_init = 1'b1;
        end
        if (rst) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_req_ready", req_ready, 0);
            expq.delete();
            outst = 0;
            after_rst = 1'b1;
        end else begin
            exp_ready = after_rst ? 1'b0 : (outst < DEPTH);
            chk("req_ready", req_ready, exp_ready);
            acc = req_valid && req_ready;
            exp_we = (acc && req_we) ? req_be : 8'h00;
            chk("mem_en", mem_en, acc);
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, acc ? req_addr : 11'd0);
            chk("mem_din", mem_din, acc ? req_wdata : 64'd0);
            exp_valid = (expq.size() > 0) && (expq[0].cyc <= cyc - 2);
            chk("rsp_valid", rsp_valid, exp_valid);
            if (rsp_valid && exp_valid) begin
                chk("rsp_id", rsp_id, expq[0].id);
                chk("rsp_rdata", rsp_rdata, expq[0].data);
                chk("rsp_wr", rsp_wr, expq[0].wr);
            end
            if (rsp_valid && rsp_ready && expq.size() > 0) begin
                popped_ids.push_back(rsp_id);
                void'(expq.pop_front());
                outst--;
            end
            if (acc) begin
                if (req_we) begin
                    w = shadow[req_addr];
                    for (int b = 0; b < 8; b++)
                        if (req_be[b]) w[b*8 +: 8] = req_wdata[b*8 +: 8];
                    shadow[req_addr] = w;
                    if (WRACK) begin
                        expq.push_back('{1'b1, 64'd0, req_id, cyc});
                        outst++;
                    end
                end else begin
                    expq.push_back('{1'b0, shadow[req_addr], req_id, cyc});
                    outst++;
                end
            end
            chk("outstanding_bound", outst <= DEPTH, 1);
            after_rst = 1'b0;
        end
    end

    task automatic send(input bit we, input logic [10:0] a, input logic [63:0] d,
                        input logic [7:0] be, input logic [3:0] id);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        req_id    = id;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", req_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat, output logic [63:0] d,
                            output logic [3:0] id, output logic wr);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        d  = rsp_rdata;
        id = rsp_id;
        wr = rsp_wr;
    endtask

    initial begin
        int          lat;
        int          n;
        logic [63:0] d;
        logic [3:0]  id;
        logic        wr;

        rst = 1'b1;
        ram_init = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        req_id = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 ram_init = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("init_ready_lo", req_ready, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        chk("init_mem_en", mem_en, 0);
        @(negedge clk);
        chk("init_ready_hi", req_ready, 1);
        @(posedge clk);
        #1;

        send(1'b1, 11'h005, 64'h0123456789ABCDEF, 8'hFF, 4'd0);
        idle();
        drain(4);
        send(1'b0, 11'h005, 64'd0, 8'h00, 4'd3);
        idle();
        wait_rsp(lat, d, id, wr);
        chk("rd1_latency", lat, 2);
        chk("rd1_data", d, 64'h0123456789ABCDEF);
        chk("rd1_id", id, 4'd3);
        chk("rd1_wr", wr, 1'b0);
        drain(1);

        send(1'b1, 11'h005, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 4'd1);
        idle();
        drain(4);
        send(1'b0, 11'h005, 64'd0, 8'h00, 4'd9);
        idle();
        wait_rsp(lat, d, id, wr);
        chk("rd2_latency", lat, 2);
        chk("rd2_data", d, 64'h01234567FFFFFFFF);
        chk("rd2_id", id, 4'd9);
        drain(1);

        rsp_ready = 1'b0;
        send(1'b0, 11'h010, 64'd0, 8'h00, 4'd1);
        send(1'b0, 11'h011, 64'd0, 8'h00, 4'd2);
        req_addr = 11'h012;
        req_id   = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_ready_lo", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        send(1'b0, 11'h012, 64'd0, 8'h00, 4'd3);
        idle();
        drain(6);
        n = popped_ids.size();
        chk("order_count", n >= 3, 1);
        if (n >= 3) begin
            chk("order_0", popped_ids[n-3], 4'd1);
            chk("order_1", popped_ids[n-2], 4'd2);
            chk("order_2", popped_ids[n-1], 4'd3);
        end

        send(1'b1, 11'h030, 64'hDEADBEEFCAFEF00D, 8'hFF, 4'd7);
        idle();
`ifdef DUALMEM_PORT_CTRL_WRACK_EN
        wait_rsp(lat, d, id, wr);
        chk("wrack_latency", lat, 2);
        chk("wrack_wr", wr, 1'b1);
        chk("wrack_id", id, 4'd7);
        chk("wrack_data", d, 64'd0);
`else
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_wr_rsp", rsp_valid, 0);
        end
`endif
        drain(3);

        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(1'b0, 11'($urandom_range(0, 2047)), 64'd0, 8'h00, 4'($urandom));
        end
        idle();
        drain(6);

        for (int i = 0; i < 300; i++) begin
            rsp_ready = ($urandom % 4) != 0;
            req_valid = $urandom % 2;
            req_we    = ($urandom % 3) == 0;
            req_addr  = 11'($urandom_range(0, 15));
            req_wdata = {$urandom, $urandom};
            req_be    = 8'($urandom);
            req_id    = 4'($urandom);
            @(posedge clk);
            #1;
        end
        idle();
        rsp_ready = 1'b1;
        drain(8);

        send(1'b0, 11'h040, 64'd0, 8'h00, 4'd5);
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid_a", rsp_valid, 0);
        chk("mrst_ready_lo", req_ready, 0);
        @(negedge clk);
        chk("mrst_valid_b", rsp_valid, 0);
        chk("mrst_ready_hi", req_ready, 1);
        @(negedge clk);
        chk("mrst_valid_c", rsp_valid, 0);
        @(posedge clk);
        #1;

        send(1'b0, 11'h030, 64'd0, 8'h00, 4'd2);
        idle();
        wait_rsp(lat, d, id, wr);
        chk("post_rst_data", d, 64'hDEADBEEFCAFEF00D);
        drain(6);
        chk("final_queue_empty", expq.size(), 0);
        chk("final_rsp_valid", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
